// File: rtl/micro_alpha_veryl_machine_data_pkg.sv
// MICRO-1 machine data types shared across the datapath.
package micro_alpha_veryl_machine_data_pkg;
  typedef logic [15:0] micro1_machine_word_t;
endpackage

// File: rtl/micro_alpha_veryl_shifter_pkg.sv
// Shift-stage types: operating modes and shift count.
package micro_alpha_veryl_shifter_pkg;
  typedef enum logic [2:0] {
    NONE = 3'd0,
    SLL  = 3'd1,
    SRL  = 3'd2,
    SRA  = 3'd3,
    ROL  = 3'd4,
    ROR  = 3'd5,
    RLC  = 3'd6,
    RRC  = 3'd7
  } shift_mode_t;

  typedef logic [3:0] shift_amount_t;
endpackage

// File: rtl/micro_alpha_veryl_shift_step.sv
// One-position shift/rotate step: (mode, d, c) -> (d_next, c_next), purely combinational.
module micro_alpha_veryl_shift_step
  import micro_alpha_veryl_machine_data_pkg::*;
  import micro_alpha_veryl_shifter_pkg::*;
(
  input  shift_mode_t          mode,
  input  micro1_machine_word_t d,
  input  logic                 c,
  output micro1_machine_word_t d_next,
  output logic                 c_next
);

  always_comb begin
    d_next = d;
    c_next = c;
    case (mode)
      SLL: begin c_next = d[15]; d_next = {d[14:0], 1'b0};  end
      SRL: begin c_next = d[0];  d_next = {1'b0, d[15:1]};  end
      SRA: begin c_next = d[0];  d_next = {d[15], d[15:1]}; end
      ROL: begin c_next = d[15]; d_next = {d[14:0], d[15]}; end
      ROR: begin c_next = d[0];  d_next = {d[0], d[15:1]};  end
      // RLC/RRC treat {c, d} as one 17-bit ring
      RLC: begin c_next = d[15]; d_next = {d[14:0], c};     end
      RRC: begin c_next = d[0];  d_next = {c, d[15:1]};     end
      default: begin d_next = d; c_next = c; end
    endcase
  end

endmodule

// File: rtl/micro_alpha_veryl_shifter.sv
// Post-ALU shift stage with valid/ready on both sides; bit-serial by default,
// single-cycle barrel when MICRO_ALPHA_VERYL_SHIFTER_FAST_EN is defined.
//
// state | meaning
// IDLE  | no operation held, ready for input
// SHIFT | stepping one position per cycle (serial build only)
// DONE  | result presented, waiting for i_ready
module micro_alpha_veryl_shifter
  import micro_alpha_veryl_machine_data_pkg::*;
  import micro_alpha_veryl_shifter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  micro1_machine_word_t i_data,
  input  logic                 i_cin,
  input  shift_mode_t          i_mode,
  input  shift_amount_t        i_amount,
  output logic                 o_valid,
  input  logic                 i_ready,
  output micro1_machine_word_t o_data,
  output logic                 o_carry,
  output logic                 o_zero,
  output logic                 o_sign
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
`ifndef MICRO_ALPHA_VERYL_SHIFTER_FAST_EN
  localparam logic [1:0] ST_SHIFT = 2'd1;
`endif
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]           state;
  logic                 accept;
  micro1_machine_word_t ld_data;
  logic                 ld_carry;
  logic [1:0]           ld_state;

  assign o_ready = (state == ST_IDLE) || ((state == ST_DONE) && i_ready);
  assign accept  = i_valid && o_ready;
  assign o_valid = (state == ST_DONE);

`ifdef MICRO_ALPHA_VERYL_SHIFTER_FAST_EN
  // Unrolled chain of steps; stage i is applied only when i < amount
  micro1_machine_word_t bar_d [16];
  logic                 bar_c [16];

  assign bar_d[0] = i_data;
  assign bar_c[0] = i_cin;

  for (genvar i = 0; i < 15; i++) begin : g_stage
    micro1_machine_word_t sd;
    logic                 sc;

    micro_alpha_veryl_shift_step u_step (
      .mode   (i_mode),
      .d      (bar_d[i]),
      .c      (bar_c[i]),
      .d_next (sd),
      .c_next (sc)
    );

    assign bar_d[i+1] = (i_amount > shift_amount_t'(i)) ? sd : bar_d[i];
    assign bar_c[i+1] = (i_amount > shift_amount_t'(i)) ? sc : bar_c[i];
  end

  assign ld_data  = bar_d[15];
  assign ld_carry = bar_c[15];
  assign ld_state = ST_DONE;
`else
  shift_mode_t          mode_q;
  shift_amount_t        cnt_q;
  micro1_machine_word_t step_d;
  logic                 step_c;

  micro_alpha_veryl_shift_step u_step (
    .mode   (mode_q),
    .d      (o_data),
    .c      (o_carry),
    .d_next (step_d),
    .c_next (step_c)
  );

  assign ld_data  = i_data;
  assign ld_carry = i_cin;
  assign ld_state = ((i_mode == NONE) || (i_amount == '0)) ? ST_DONE : ST_SHIFT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= NONE;
      cnt_q  <= '0;
    end else if (accept) begin
      mode_q <= i_mode;
      cnt_q  <= i_amount;
    end else if (state == ST_SHIFT) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      o_data  <= '0;
      o_carry <= 1'b0;
      o_zero  <= 1'b1;
      o_sign  <= 1'b0;
    end else if (accept) begin
      state   <= ld_state;
      o_data  <= ld_data;
      o_carry <= ld_carry;
      o_zero  <= (ld_data == '0);
      o_sign  <= ld_data[15];
    end else if ((state == ST_DONE) && i_ready) begin
      state <= ST_IDLE;
    end
`ifndef MICRO_ALPHA_VERYL_SHIFTER_FAST_EN
    else if (state == ST_SHIFT) begin
      o_data  <= step_d;
      o_carry <= step_c;
      o_zero  <= (step_d == '0);
      o_sign  <= step_d[15];
      // terminal count: this step is the last position
      if (cnt_q == 4'd1) state <= ST_DONE;
    end
`endif
  end

endmodule

// File: tb/tb_micro_alpha_veryl_shifter.sv
// Scoreboard bench for micro_alpha_veryl_shifter (serial or FAST_EN build).
module tb_micro_alpha_veryl_shifter;
  import micro_alpha_veryl_machine_data_pkg::*;
  import micro_alpha_veryl_shifter_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_valid;
  logic                 o_ready;
  micro1_machine_word_t i_data;
  logic                 i_cin;
  shift_mode_t          i_mode;
  shift_amount_t        i_amount;
  logic                 o_valid;
  logic                 i_ready;
  micro1_machine_word_t o_data;
  logic                 o_carry;
  logic                 o_zero;
  logic                 o_sign;

  micro_alpha_veryl_shifter dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data   (i_data),
    .i_cin    (i_cin),
    .i_mode   (i_mode),
    .i_amount (i_amount),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_carry  (o_carry),
    .o_zero   (o_zero),
    .o_sign   (o_sign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        carry;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   first_cyc = 0;
  bit   pending_new = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input shift_mode_t m, input logic [3:0] a);
`ifdef MICRO_ALPHA_VERYL_SHIFTER_FAST_EN
    return 1;
`else
    return (m == NONE || a == 4'd0) ? 1 : 1 + int'(a);
`endif
  endfunction

  // Monitor: compares whenever a result is presented
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid) begin
        if (pending_new) begin
          first_cyc   = cyc;
          pending_new = 1'b0;
        end
        if (sb.size() == 0) begin
          chk("spurious_valid", 32'(o_valid), 32'd0);
        end else if (i_ready) begin
          chk({sb[0].name, "_data"},  32'(o_data),  32'(sb[0].data));
          chk({sb[0].name, "_carry"}, 32'(o_carry), 32'(sb[0].carry));
          chk({sb[0].name, "_zero"},  32'(o_zero),  32'(sb[0].data == 16'h0));
          chk({sb[0].name, "_sign"},  32'(o_sign),  32'(sb[0].data[15]));
          if (acc_q.size() > 0) begin
            chk({sb[0].name, "_latency"}, 32'(first_cyc - acc_q[0]), 32'(sb[0].lat));
            void'(acc_q.pop_front());
          end
          void'(sb.pop_front());
          pending_new = 1'b1;
        end else begin
          chk({sb[0].name, "_hold_data"},  32'(o_data),  32'(sb[0].data));
          chk({sb[0].name, "_hold_carry"}, 32'(o_carry), 32'(sb[0].carry));
          chk({sb[0].name, "_hold_ready"}, 32'(o_ready), 32'd0);
        end
      end else begin
        pending_new = 1'b1;
      end
    end
  end

  // Called just after a rising edge; returns after the accept edge.
  task automatic issue(input string name, input shift_mode_t m, input logic [15:0] d,
                       input logic c, input logic [3:0] a,
                       input logic [15:0] ed, input logic ec, output int waited);
    bit acc;
    exp_t e;
    e.data = ed; e.carry = ec; e.lat = exp_lat(m, a); e.name = name;
    sb.push_back(e);
    i_valid = 1'b1; i_mode = m; i_data = d; i_cin = c; i_amount = a;
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = o_ready;
      if (acc) acc_q.push_back(cyc);
      waited++;
      @(posedge clk); #1;
    end
    if (!acc) chk({name, "_accept_timeout"}, 32'(o_ready), 32'd1);
    i_valid = 1'b0; i_data = 16'hDEAD; i_cin = 1'b1; i_mode = RRC; i_amount = 4'd9;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    if (sb.size() != 0) chk({name, "_drain_timeout"}, 32'(sb.size()), 32'd0);
  endtask

  int w;

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_data = '0; i_cin = 1'b0; i_mode = NONE; i_amount = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data",  32'(o_data),  32'd0);
    chk("rst_carry", 32'(o_carry), 32'd0);
    chk("rst_zero",  32'(o_zero),  32'd1);
    chk("rst_sign",  32'(o_sign),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(o_ready), 32'd1);
    @(posedge clk); #1;

    // back-to-back directed vectors with i_ready high
    issue("sll4",   SLL,  16'h0001, 1'b0, 4'd4,  16'h0010, 1'b0, w);
    issue("sra3",   SRA,  16'h8000, 1'b0, 4'd3,  16'hF000, 1'b0, w);
    issue("ror1",   ROR,  16'h0001, 1'b0, 4'd1,  16'h8000, 1'b1, w);
    issue("rlc1",   RLC,  16'h8000, 1'b0, 4'd1,  16'h0000, 1'b1, w);
    issue("rrc1",   RRC,  16'h0001, 1'b1, 4'd1,  16'h8000, 1'b1, w);
    issue("none7",  NONE, 16'hA5A5, 1'b1, 4'd7,  16'hA5A5, 1'b1, w);
    issue("sll0",   SLL,  16'h1234, 1'b1, 4'd0,  16'h1234, 1'b1, w);
    issue("rol15",  ROL,  16'h8001, 1'b0, 4'd15, 16'hC000, 1'b0, w);
    issue("srl15",  SRL,  16'h8001, 1'b1, 4'd15, 16'h0001, 1'b0, w);
    issue("rlc15",  RLC,  16'h0001, 1'b1, 4'd15, 16'hC000, 1'b0, w);
    drain("seq");

    // backpressure then same-cycle accept of the next op
    i_ready = 1'b0;
    issue("bp_sll8", SLL, 16'h00FF, 1'b0, 4'd8, 16'hFF00, 1'b0, w);
    begin
      int n = 0;
      while (!o_valid && n < 100) begin @(posedge clk); #1; n++; end
      if (!o_valid) chk("bp_wait_valid", 32'(o_valid), 32'd1);
    end
    repeat (3) @(posedge clk);
    #1;
    i_ready = 1'b1;
    issue("bp_srl2", SRL, 16'h0004, 1'b0, 4'd2, 16'h0001, 1'b0, w);
    chk("bp_no_bubble_wait", 32'(w), 32'd1);
    drain("bp");

    // reset in the middle of a long shift (or while DONE in the fast build)
    i_ready = 1'b0;
    issue("rst_sll10", SLL, 16'h0003, 1'b0, 4'd10, 16'h0C00, 1'b0, w);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    acc_q.delete();
    @(negedge clk);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_data",  32'(o_data),  32'd0);
    chk("midrst_carry", 32'(o_carry), 32'd0);
    chk("midrst_zero",  32'(o_zero),  32'd1);
    chk("midrst_sign",  32'(o_sign),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    i_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    issue("post_ror4", ROR, 16'h00F0, 1'b0, 4'd4, 16'h000F, 1'b0, w);
    drain("post");

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
